seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 131 +++++++++++++
 tb/tb_seq_divider.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Results are registered on entry to DONE and held until the consumer takes them.
module seq_divider #(
   parameter int DW = 32,
   parameter int VW = 16,
   parameter int QW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic          ready,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [QW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_zero,
   output logic          ovf
);

   localparam int CW = $clog2(DW);
   localparam int PW = VW + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [DW-1:0] r_dvd;
   logic [VW-1:0] r_dvs;
   logic [PW-1:0] r_prem;
   logic [CW-1:0] r_cnt;
   logic          r_zero;
   logic [QW-1:0] r_quot;
   logic [VW-1:0] r_rem;
   logic          r_dz;
   logic          r_ovf;

   logic [PW:0]   w_shift;
   logic          w_ge;
   logic [PW-1:0] w_pnext;
   logic [DW-1:0] w_qnext;
   logic          w_hi;
   logic          w_last;

   // r_dvd doubles as the quotient register: dividend bits leave at the top
   // while quotient bits enter at the bottom.
   assign w_shift = {r_prem, r_dvd[DW-1]};
   assign w_ge    = w_shift >= {2'b00, r_dvs};
   assign w_pnext = w_ge ? PW'(w_shift - {2'b00, r_dvs}) : PW'(w_shift);
   assign w_qnext = {r_dvd[DW-2:0], w_ge};
   assign w_last  = (r_state == RUN) && (r_cnt == '0);

   generate
      if (DW > QW) begin : g_ovf
         assign w_hi = |w_qnext[DW-1:QW];
      end else begin : g_no_ovf
         assign w_hi = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = RUN;
         RUN:     if (r_cnt == '0) w_next = DONE;
         DONE:    if (out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      ready     = (r_state == IDLE);
      out_valid = (r_state == DONE);
   end

   // A zero divisor still spends one cycle in RUN (counter loaded with 0),
   // which gives the one-cycle accept-to-valid latency on that path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dvd  <= '0;
         r_dvs  <= '0;
         r_prem <= '0;
         r_cnt  <= '0;
         r_zero <= 1'b0;
         r_quot <= '0;
         r_rem  <= '0;
         r_dz   <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         if ((r_state == IDLE) && start) begin
            r_dvd  <= dividend;
            r_dvs  <= divisor;
            r_prem <= '0;
            r_zero <= (divisor == '0);
            r_cnt  <= (divisor == '0) ? '0 : CW'(DW - 1);
         end
         if (r_state == RUN) begin
            if (!r_zero) begin
               r_prem <= w_pnext;
               r_dvd  <= w_qnext;
            end
            if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
         end
         if (w_last) begin
            if (r_zero) begin
               r_quot <= '1;
               r_rem  <= r_dvd[VW-1:0];
               r_dz   <= 1'b1;
               r_ovf  <= 1'b0;
            end else begin
               r_quot <= w_qnext[QW-1:0];
               r_rem  <= w_pnext[VW-1:0];
               r_dz   <= 1'b0;
               r_ovf  <= w_hi;
            end
         end
      end
   end

   assign quotient  = r_quot;
   assign remainder = r_rem;
   assign div_zero  = r_dz;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: default-size instance for the scenarios,
// plus a DW=8/VW=4/QW=8 instance swept over every operand pair.
module tb_seq_divider;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   logic        a_start, a_ready, a_out_valid, a_out_ready, a_dz, a_ovf;
   logic [31:0] a_dividend;
   logic [15:0] a_divisor, a_quotient, a_remainder;

   logic        b_start, b_ready, b_out_valid, b_out_ready, b_dz, b_ovf;
   logic [7:0]  b_dividend, b_quotient;
   logic [3:0]  b_divisor, b_remainder;

   seq_divider u_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .ready(a_ready),
      .dividend(a_dividend), .divisor(a_divisor),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .quotient(a_quotient), .remainder(a_remainder),
      .div_zero(a_dz), .ovf(a_ovf)
   );

   seq_divider #(.DW(8), .VW(4), .QW(8)) u_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .ready(b_ready),
      .dividend(b_dividend), .divisor(b_divisor),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .quotient(b_quotient), .remainder(b_remainder),
      .div_zero(b_dz), .ovf(b_ovf)
   );

   task automatic start_a(input logic [31:0] a, input logic [15:0] b);
      a_dividend = a;
      a_divisor  = b;
      a_start    = 1'b1;
      @(posedge clk); #1;
      a_start    = 1'b0;
   endtask

   task automatic wait_a(output int lat);
      lat = 0;
      while (!a_out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      a_start = 1'b0; a_out_ready = 1'b1; a_dividend = '0; a_divisor = '0;
      b_start = 1'b0; b_out_ready = 1'b1; b_dividend = '0; b_divisor = '0;
      repeat (3) @(posedge clk);
      #1;
      n_chk++;
      if ({a_ready, a_out_valid, a_quotient, a_remainder, a_dz, a_ovf} !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_state got rdy=%b vld=%b q=%h r=%h dz=%b ovf=%b exp rdy=1 vld=0 q=0 r=0 dz=0 ovf=0",
                  a_ready, a_out_valid, a_quotient, a_remainder, a_dz, a_ovf);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic;
      int lat;
      start_a(32'd100, 16'd7);
      wait_a(lat);
      n_chk++;
      if (lat !== 32) begin n_fail++; $display("FAIL basic_latency got %0d exp 32", lat); end
      n_chk++;
      if ({a_quotient, a_remainder, a_dz, a_ovf} !== {16'd14, 16'd2, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL basic_100_7 got q=%0d r=%0d dz=%b ovf=%b exp q=14 r=2 dz=0 ovf=0", a_quotient, a_remainder, a_dz, a_ovf);
      end
      @(posedge clk); #1;
      n_chk++;
      if ({a_ready, a_out_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL basic_ready_after_hs got rdy=%b vld=%b exp rdy=1 vld=0", a_ready, a_out_valid);
      end
   endtask

   task automatic test_ovf;
      int lat;
      start_a(32'hFFFF_FFFF, 16'd1);
      wait_a(lat);
      n_chk++;
      if ({a_quotient, a_remainder, a_dz, a_ovf} !== {16'hFFFF, 16'h0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL ovf_max_by_1 got q=%h r=%h dz=%b ovf=%b exp q=ffff r=0 dz=0 ovf=1", a_quotient, a_remainder, a_dz, a_ovf);
      end
      @(posedge clk); #1;
      start_a(32'h0001_FFFE, 16'd2);
      wait_a(lat);
      n_chk++;
      if ({a_quotient, a_remainder, a_dz, a_ovf} !== {16'hFFFF, 16'h0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL ovf_fit_boundary got q=%h r=%h dz=%b ovf=%b exp q=ffff r=0 dz=0 ovf=0", a_quotient, a_remainder, a_dz, a_ovf);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_div_zero;
      int lat;
      start_a(32'h1234, 16'd0);
      wait_a(lat);
      n_chk++;
      if (lat !== 1) begin n_fail++; $display("FAIL divzero_latency got %0d exp 1", lat); end
      n_chk++;
      if ({a_quotient, a_remainder, a_dz, a_ovf} !== {16'hFFFF, 16'h1234, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL divzero_result got q=%h r=%h dz=%b ovf=%b exp q=ffff r=1234 dz=1 ovf=0", a_quotient, a_remainder, a_dz, a_ovf);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_hold;
      int lat;
      a_out_ready = 1'b0;
      start_a(32'd100, 16'd7);
      wait_a(lat);
      for (int i = 0; i < 10; i++) begin
         a_dividend = 32'd5000 + 32'(i);
         a_divisor  = 16'd3;
         a_start    = i[0];
         @(posedge clk); #1;
         n_chk++;
         if ({a_out_valid, a_ready, a_quotient, a_remainder, a_dz, a_ovf} !== {1'b1, 1'b0, 16'd14, 16'd2, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL hold_cycle%0d got vld=%b rdy=%b q=%0d r=%0d dz=%b ovf=%b exp vld=1 rdy=0 q=14 r=2 dz=0 ovf=0",
                     i, a_out_valid, a_ready, a_quotient, a_remainder, a_dz, a_ovf);
         end
      end
      a_start = 1'b0;
      a_out_ready = 1'b1;
      @(posedge clk); #1;
      n_chk++;
      if ({a_out_valid, a_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL hold_release got vld=%b rdy=%b exp vld=0 rdy=1", a_out_valid, a_ready);
      end
      @(posedge clk); #1;
      n_chk++;
      if ({a_out_valid, a_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL hold_ignored_start got vld=%b rdy=%b exp vld=0 rdy=1", a_out_valid, a_ready);
      end
   endtask

   task automatic test_back_to_back;
      int lat;
      start_a(32'd1000, 16'd3);
      wait_a(lat);
      n_chk++;
      if ({a_quotient, a_remainder} !== {16'd333, 16'd1}) begin
         n_fail++;
         $display("FAIL b2b_first got q=%0d r=%0d exp q=333 r=1", a_quotient, a_remainder);
      end
      @(posedge clk); #1;
      start_a(32'd65535, 16'd255);
      repeat (5) @(posedge clk);
      #1;
      n_chk++;
      if ({a_ready, a_out_valid, a_quotient, a_remainder} !== {1'b0, 1'b0, 16'd333, 16'd1}) begin
         n_fail++;
         $display("FAIL b2b_hold_in_run got rdy=%b vld=%b q=%0d r=%0d exp rdy=0 vld=0 q=333 r=1",
                  a_ready, a_out_valid, a_quotient, a_remainder);
      end
      wait_a(lat);
      n_chk++;
      if ({lat, a_quotient, a_remainder} !== {32'd27, 16'd257, 16'd0}) begin
         n_fail++;
         $display("FAIL b2b_second got rest_lat=%0d q=%0d r=%0d exp rest_lat=27 q=257 r=0", lat, a_quotient, a_remainder);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_run;
      int lat;
      int seen;
      start_a(32'hDEAD_BEEF, 16'h1234);
      repeat (9) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({a_ready, a_out_valid, a_quotient, a_remainder, a_dz, a_ovf} !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL midrun_reset got rdy=%b vld=%b q=%h r=%h dz=%b ovf=%b exp rdy=1 vld=0 q=0 r=0 dz=0 ovf=0",
                  a_ready, a_out_valid, a_quotient, a_remainder, a_dz, a_ovf);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (a_out_valid) seen++;
      end
      n_chk++;
      if (seen !== 0) begin n_fail++; $display("FAIL midrun_aborted_result got %0d valid cycles exp 0", seen); end
      start_a(32'd50, 16'd5);
      wait_a(lat);
      n_chk++;
      if ({lat, a_quotient, a_remainder, a_dz} !== {32'd32, 16'd10, 16'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL midrun_50_5 got lat=%0d q=%0d r=%0d dz=%b exp lat=32 q=10 r=0 dz=0", lat, a_quotient, a_remainder, a_dz);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_exhaustive_small;
      int lat;
      logic [7:0] eq;
      logic [3:0] er;
      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 16; b++) begin
            b_dividend = 8'(a);
            b_divisor  = 4'(b);
            b_start    = 1'b1;
            @(posedge clk); #1;
            b_start = 1'b0;
            lat = 0;
            while (!b_out_valid && lat < 50) begin
               @(posedge clk); #1;
               lat++;
            end
            eq = (b == 0) ? 8'hFF : 8'(a / b);
            er = (b == 0) ? 4'(a) : 4'(a % b);
            n_chk++;
            if ({lat, b_quotient, b_remainder, b_dz, b_ovf} !== {((b == 0) ? 32'd1 : 32'd8), eq, er, (b == 0), 1'b0}) begin
               n_fail++;
               $display("FAIL small_%0d_div_%0d got lat=%0d q=%0d r=%0d dz=%b ovf=%b exp lat=%0d q=%0d r=%0d dz=%b ovf=0",
                        a, b, lat, b_quotient, b_remainder, b_dz, b_ovf, (b == 0) ? 1 : 8, eq, er, (b == 0));
            end
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ovf();
      test_div_zero();
      test_hold();
      test_back_to_back();
      test_reset_mid_run();
      test_exhaustive_small();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
